// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and default constants for the keypad lock controller
//
// Contents: state encoding, BCD digit type, default parameter values and a
// BCD range helper. States list gains ST_PROG only when LOCK_PROG_EN is defined.
// No ports.

package lock_pkg;

    localparam int          DEF_DIGITS         = 4;
    localparam logic [15:0] DEF_RESET_CODE     = 16'h1234;
    localparam int          DEF_MAX_TRIES      = 3;
    localparam int          DEF_OPEN_CYCLES    = 256;
    localparam int          DEF_LOCKOUT_CYCLES = 1024;

    typedef logic [3:0] bcd_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_LOCKOUT = 3'd5
`ifdef LOCK_PROG_EN
        ,
        ST_PROG    = 3'd6
`endif
    } state_t;

    function automatic logic is_bcd(input bcd_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter shared by the OPEN and LOCKOUT holds
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load load_val this cycle (has priority over dec)
//   load_val     value loaded; hold lasts load_val+1 cycles until done
//   dec          count down by one; stops at zero, never wraps
//   done         count has reached zero

module lock_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lock_seq_ctrl.sv
// rtl/lock_seq_ctrl.sv - BCD keypad code lock sequencer with try limit and lockout
//
// Optional feature macro: LOCK_PROG_EN (code reprogramming from the OPEN state).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   key_valid    digit strobe; digit taken when key_valid & key_ready & ~clear
//   key_digit    entered BCD digit
//   key_ready    controller accepts a digit this cycle (IDLE/ENTRY/PROG)
//   clear        abort entry / relock; ignored during lockout
//   prog         start reprogramming from OPEN (LOCK_PROG_EN builds only)
//   unlocked     lock open
//   locked       always ~unlocked
//   alarm        lockout active
//   digit_cnt    digits accepted in the current entry
//   last_digit   most recently accepted digit

module lock_seq_ctrl
    import lock_pkg::*;
#(
    parameter int                  DIGITS         = DEF_DIGITS,
    parameter logic [4*DIGITS-1:0] RESET_CODE     = DEF_RESET_CODE,
    parameter int                  MAX_TRIES      = DEF_MAX_TRIES,
    parameter int                  OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int                  LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       key_ready,
    input  logic       clear,
    input  logic       prog,
    output logic       unlocked,
    output logic       locked,
    output logic       alarm,
    output logic [2:0] digit_cnt,
    output logic [3:0] last_digit
);

    localparam int CODE_W  = 4 * DIGITS;
    localparam int TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int TRY_W   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;

    localparam logic [2:0]       LAST_IDX   = 3'(DIGITS - 1);
    localparam logic [TRY_W-1:0] TRIES_LAST = TRY_W'(MAX_TRIES - 1);
    // The timer counts load_val..0 inclusive, so a hold of N cycles loads N-1.
    localparam logic [TMR_W-1:0] OPEN_LOAD  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);

    state_t            state;
    logic [TRY_W-1:0]  tries;
    logic              mismatch;
    logic              ready_en;
    logic [CODE_W-1:0] code;
    bcd_t              code_digit;
    logic              accept;
    logic              fail_lock;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_dec;
    logic              tmr_done;

`ifdef LOCK_PROG_EN
    logic [CODE_W-1:0] shadow;
    logic [CODE_W-1:0] shadow_next;

    assign shadow_next = CODE_W'({shadow, key_digit});
`else
    logic unused_prog;

    assign unused_prog = prog;
    assign code        = RESET_CODE;
`endif

    // ready_en holds key_ready low while reset is asserted, then lets the
    // state decode through from the first edge after release.
    assign key_ready = ready_en && ((state == ST_IDLE) || (state == ST_ENTRY)
`ifdef LOCK_PROG_EN
                                    || (state == ST_PROG)
`endif
                                   );

    assign accept     = key_valid && key_ready && !clear;
    assign code_digit = bcd_t'(code >> (4 * (LAST_IDX - digit_cnt)));
    assign fail_lock  = (tries >= TRIES_LAST);
    assign locked     = ~unlocked;

    assign tmr_load = ((state == ST_CHECK) && !mismatch) ||
                      ((state == ST_FAIL) && fail_lock);
    assign tmr_val  = (state == ST_CHECK) ? OPEN_LOAD : LOCK_LOAD;
    // No decrement in PROG: the open hold is frozen while a new code is keyed.
    assign tmr_dec  = (state == ST_OPEN) || (state == ST_LOCKOUT);

    lock_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tries      <= '0;
            mismatch   <= 1'b0;
            digit_cnt  <= '0;
            last_digit <= '0;
            unlocked   <= 1'b0;
            alarm      <= 1'b0;
            ready_en   <= 1'b0;
`ifdef LOCK_PROG_EN
            code       <= RESET_CODE;
            shadow     <= '0;
`endif
        end else begin
            ready_en <= 1'b1;
            case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (clear) begin
                        state     <= ST_IDLE;
                        digit_cnt <= '0;
                        mismatch  <= 1'b0;
                    end else if (accept) begin
                        last_digit <= key_digit;
                        digit_cnt  <= digit_cnt + 3'd1;
                        if (!is_bcd(key_digit) || (key_digit != code_digit)) begin
                            mismatch <= 1'b1;
                        end
                        state <= (digit_cnt == LAST_IDX) ? ST_CHECK : ST_ENTRY;
                    end
                end

                ST_CHECK: begin
                    if (mismatch) begin
                        state <= ST_FAIL;
                    end else begin
                        state    <= ST_OPEN;
                        unlocked <= 1'b1;
                        tries    <= '0;
                    end
                end

                ST_OPEN: begin
                    if (clear || tmr_done) begin
                        state     <= ST_IDLE;
                        unlocked  <= 1'b0;
                        digit_cnt <= '0;
                        mismatch  <= 1'b0;
`ifdef LOCK_PROG_EN
                    end else if (prog) begin
                        state     <= ST_PROG;
                        digit_cnt <= '0;
`endif
                    end
                end

                ST_FAIL: begin
                    digit_cnt <= '0;
                    mismatch  <= 1'b0;
                    if (fail_lock) begin
                        state <= ST_LOCKOUT;
                        tries <= '0;
                        alarm <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        tries <= tries + 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    if (tmr_done) begin
                        state     <= ST_IDLE;
                        alarm     <= 1'b0;
                        digit_cnt <= '0;
                        mismatch  <= 1'b0;
                    end
                end

`ifdef LOCK_PROG_EN
                ST_PROG: begin
                    if (clear || (accept && !is_bcd(key_digit))) begin
                        state     <= ST_IDLE;
                        unlocked  <= 1'b0;
                        digit_cnt <= '0;
                        mismatch  <= 1'b0;
                    end else if (accept) begin
                        last_digit <= key_digit;
                        shadow     <= shadow_next;
                        if (digit_cnt == LAST_IDX) begin
                            code      <= shadow_next;
                            state     <= ST_IDLE;
                            unlocked  <= 1'b0;
                            digit_cnt <= '0;
                            mismatch  <= 1'b0;
                        end else begin
                            digit_cnt <= digit_cnt + 3'd1;
                        end
                    end
                end
`endif

                default: begin
                    state     <= ST_IDLE;
                    unlocked  <= 1'b0;
                    alarm     <= 1'b0;
                    digit_cnt <= '0;
                    mismatch  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// tb/tb_lock_seq_ctrl.sv - directed scoreboard bench for lock_seq_ctrl

module tb_lock_seq_ctrl;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       clear = 1'b0;
    logic       prog = 1'b0;
    logic       key_ready;
    logic       unlocked;
    logic       locked;
    logic       alarm;
    logic [2:0] digit_cnt;
    logic [3:0] last_digit;

    always #5 clk = ~clk;

    lock_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_ready  (key_ready),
        .clear      (clear),
        .prog       (prog),
        .unlocked   (unlocked),
        .locked     (locked),
        .alarm      (alarm),
        .digit_cnt  (digit_cnt),
        .last_digit (last_digit)
    );

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_q.push_back('{tag: tag, val: val});
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $error("FAIL sb_empty observed=%0h expected=<queued value>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    // Counts consecutive sampled cycles with unlocked (sel=0) or alarm (sel=1) high.
    task automatic hold_len(input logic sel, output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            if ((sel ? alarm : unlocked) !== 1'b1) break;
            n++;
            tick();
        end
    endtask

    // Three wrong entries starting from IDLE with tries=0; ends in first LOCKOUT cycle.
    task automatic three_fails();
        for (int k = 0; k < 3; k++) begin
            enter4(4'd1, 4'd2, 4'd3, 4'd5);
            tick();
            tick();
        end
    endtask

    int n;
    logic bad_ready;

    initial begin
        // Reset values while rst_n is held low
        sb_push("rst_ready", 0);
        sb_push("rst_unlocked", 0);
        sb_push("rst_locked", 1);
        sb_push("rst_alarm", 0);
        sb_push("rst_cnt", 0);
        sb_push("rst_last", 0);
        tick();
        tick();
        sb_check(key_ready);
        sb_check(unlocked);
        sb_check(locked);
        sb_check(alarm);
        sb_check(digit_cnt);
        sb_check(last_digit);
        rst_n = 1'b1;
        sb_push("ready_after_rst", 1);
        tick();
        sb_check(key_ready);

        // Correct code opens for 256 cycles
        sb_push("cnt_1", 1);
        sb_push("last_1", 1);
        press(4'd1);
        sb_check(digit_cnt);
        sb_check(last_digit);
        sb_push("check_cnt", 4);
        sb_push("check_ready", 0);
        sb_push("check_unlocked", 0);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        sb_check(digit_cnt);
        sb_check(key_ready);
        sb_check(unlocked);
        sb_push("open_locked", 0);
        sb_push("open_len", 256);
        sb_push("post_open_ready", 1);
        sb_push("post_open_cnt", 0);
        tick();
        sb_check(locked);
        hold_len(1'b0, n);
        sb_check(n);
        sb_check(key_ready);
        sb_check(digit_cnt);

        // Non-BCD digit forces a failed attempt
        sb_push("bad_digit_unlocked", 0);
        sb_push("bad_digit_tries", 1);
        sb_push("bad_digit_ready", 1);
        enter4(4'd1, 4'd2, 4'hA, 4'd4);
        tick();
        tick();
        sb_check(unlocked);
        sb_check(dut.tries);
        sb_check(key_ready);

        // Clear wins over a simultaneous digit
        press(4'd1);
        press(4'd2);
        sb_push("clr_cnt", 0);
        sb_push("clr_last", 2);
        sb_push("clr_tries", 1);
        clear = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd3;
        tick();
        clear = 1'b0;
        key_valid = 1'b0;
        sb_check(digit_cnt);
        sb_check(last_digit);
        sb_check(dut.tries);
        sb_push("partial_cnt", 2);
        sb_push("partial_unlocked", 0);
        press(4'd3);
        press(4'd4);
        tick();
        tick();
        sb_check(digit_cnt);
        sb_check(unlocked);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Unlock then clear relocks next cycle and clears tries
        sb_push("relock_unlocked", 0);
        sb_push("relock_tries", 0);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sb_check(unlocked);
        sb_check(dut.tries);

        // Three failures enter lockout for 1024 cycles, keys and clear ignored
        sb_push("two_fail_alarm", 0);
        sb_push("two_fail_tries", 2);
        for (int k = 0; k < 2; k++) begin
            enter4(4'd1, 4'd2, 4'd3, 4'd5);
            tick();
            tick();
        end
        sb_check(alarm);
        sb_check(dut.tries);
        sb_push("lockout_alarm", 1);
        sb_push("lockout_len", 1024);
        sb_push("lockout_ready", 0);
        sb_push("lockout_last", 5);
        sb_push("post_lock_alarm", 0);
        sb_push("post_lock_ready", 1);
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        tick();
        tick();
        sb_check(alarm);
        n = 0;
        bad_ready = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (alarm !== 1'b1) break;
            n++;
            if (key_ready !== 1'b0) bad_ready = 1'b1;
            key_valid = 1'b1;
            key_digit = 4'(i % 10);
            clear = 1'($urandom_range(0, 1));
            tick();
        end
        key_valid = 1'b0;
        clear = 1'b0;
        sb_check(n);
        sb_check(bad_ready);
        sb_check(last_digit);
        sb_check(alarm);
        sb_check(key_ready);

        // Reset in the middle of lockout
        three_fails();
        repeat (50) tick();
        sb_push("mid_lock_alarm", 1);
        sb_push("rst_async_alarm", 0);
        sb_push("rst_async_ready", 0);
        sb_push("rel_ready", 1);
        sb_push("rel_open", 1);
        sb_check(alarm);
        #2;
        rst_n = 1'b0;
        #1;
        sb_check(alarm);
        sb_check(key_ready);
        tick();
        rst_n = 1'b1;
        tick();
        sb_check(key_ready);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        sb_check(unlocked);
        clear = 1'b1;
        tick();
        clear = 1'b0;

`ifdef LOCK_PROG_EN
        // Reprogram to 9876, old code fails, new code opens, reset restores
        sb_push("prog_ready", 1);
        sb_push("prog_done_unlocked", 0);
        sb_push("prog_done_ready", 1);
        sb_push("old_code_unlocked", 0);
        sb_push("old_code_tries", 1);
        sb_push("new_code_unlocked", 1);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        prog = 1'b1;
        tick();
        prog = 1'b0;
        sb_check(key_ready);
        enter4(4'd9, 4'd8, 4'd7, 4'd6);
        sb_check(unlocked);
        sb_check(key_ready);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        tick();
        sb_check(unlocked);
        sb_check(dut.tries);
        enter4(4'd9, 4'd8, 4'd7, 4'd6);
        tick();
        sb_check(unlocked);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        sb_push("restored_unlocked", 1);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        sb_check(unlocked);
`endif

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
